// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Single-port, word-addressed on-chip RAM shared by two requesters:
//   * IF  - instruction fetch, read-only
//   * MEM - data access, read/write with per-byte write strobes
//
// One access is accepted per cycle. Requests use a valid/ready handshake
// (ready is combinational), responses are one-cycle rsp_valid pulses issued
// exactly one cycle after the accept edge. Conflicts are resolved either with
// fixed priority (MEM wins) or round-robin (alternate on conflict).
//
// Parameters
//   DATA_WIDTH  word width in bits (multiple of 8)
//   ADDR_WIDTH  word address width, depth = 2**ADDR_WIDTH
//   ARB_MODE    0 = MEM always wins a conflict, 1 = round-robin
//   CNT_WIDTH   width of the saturating stall counters
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   if_req_valid / if_req_ready     IF request handshake
//   if_addr                         IF word address
//   if_rsp_valid / if_rsp_data      IF read response (pulse / held data)
//   mem_req_valid / mem_req_ready   MEM request handshake
//   mem_req_write                   1 = write, 0 = read
//   mem_addr, mem_wdata, mem_wstrb  MEM address, write data, byte enables
//   mem_rsp_valid / mem_rsp_data    MEM completion pulse / held read data
//   if_stall_cnt, mem_stall_cnt     saturating counts of valid && !ready
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,

    input  logic                    mem_req_valid,
    output logic                    mem_req_ready,
    input  logic                    mem_req_write,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,

    output logic [CNT_WIDTH-1:0]    if_stall_cnt,
    output logic [CNT_WIDTH-1:0]    mem_stall_cnt
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Which requester won the most recent accept; drives round-robin.
    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t                  last_grant;
    grant_t                  last_grant_nxt;

    logic                    if_accept;
    logic                    mem_accept;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    // -------------------------------------------------------------------------
    // Grant register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_IF;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration: ready is a pure function of the two valids and last_grant,
    // held low while reset is asserted so nothing can be accepted then.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        if_req_ready   = 1'b0;
        mem_req_ready  = 1'b0;
        last_grant_nxt = last_grant;

        if (!reset) begin
            unique case ({if_req_valid, mem_req_valid})
                2'b10: if_req_ready  = 1'b1;
                2'b01: mem_req_ready = 1'b1;
                2'b11: begin
                    if (ARB_MODE == 0) begin
                        mem_req_ready = 1'b1;
                    end else if (last_grant == GRANT_IF) begin
                        mem_req_ready = 1'b1;
                    end else begin
                        if_req_ready  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (if_req_valid && if_req_ready) begin
            last_grant_nxt = GRANT_IF;
        end else if (mem_req_valid && mem_req_ready) begin
            last_grant_nxt = GRANT_MEM;
        end
    end

    assign if_accept  = if_req_valid  && if_req_ready;
    assign mem_accept = mem_req_valid && mem_req_ready;

    // -------------------------------------------------------------------------
    // Single RAM port: the accepted requester owns the address this cycle.
    // -------------------------------------------------------------------------
    assign ram_addr  = mem_accept ? mem_addr : if_addr;
    assign ram_rdata = ram[ram_addr];

    // NOTE: the RAM array has no reset; clearing it would cost a write per word
    // and its contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (mem_accept && mem_req_write) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (mem_wstrb[b]) begin
                    ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Responses: one-cycle pulse after the accept edge. Read data is captured at
    // the accept edge and held until the next read for that requester; writes
    // leave mem_rsp_data untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
        end else begin
            if_rsp_valid  <= if_accept;
            mem_rsp_valid <= mem_accept;
            if (if_accept) begin
                if_rsp_data <= ram_rdata;
            end
            if (mem_accept && !mem_req_write) begin
                mem_rsp_data <= ram_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall counters, cleared only by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (if_req_valid && !if_req_ready && (if_stall_cnt != CNT_MAX)) begin
                if_stall_cnt <= if_stall_cnt + 1'b1;
            end
            if (mem_req_valid && !mem_req_ready && (mem_stall_cnt != CNT_MAX)) begin
                mem_stall_cnt <= mem_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Three arbiters share one directed stimulus stream:
//   dut0: ARB_MODE=0, CNT_WIDTH=16
//   dut1: ARB_MODE=1, CNT_WIDTH=16
//   dut2: ARB_MODE=0, CNT_WIDTH=4
// A behavioural model per instance (grant rule, word-array RAM, response
// slots, saturating counters) is compared against every DUT output at each
// falling edge. A probe code set with each stimulus step adds hand-computed
// literal expectations at that same falling edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int N = 3;

    localparam int P_NONE    = 0;
    localparam int P_IDLE    = 1;
    localparam int P_WR_RSP  = 2;
    localparam int P_RD_BEEF = 3;
    localparam int P_IF_AA   = 4;
    localparam int P_IF_END  = 5;
    localparam int P_CONF    = 10;   // 10..13: k-th conflict cycle
    localparam int P_AFTER   = 20;
    localparam int P_SAT     = 21;
    localparam int P_RST     = 22;
    localparam int P_RD7     = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_v;
    logic [10:0] if_a;
    logic        m_v;
    logic        m_w;
    logic [10:0] m_a;
    logic [31:0] m_d;
    logic [3:0]  m_s;
    int          probe;

    logic [N-1:0]       if_rdy, mem_rdy, if_rv, mem_rv;
    logic [N-1:0][31:0] if_rd, mem_rd;
    logic [N-1:0][15:0] if_sc, mem_sc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = (g == 2) ? 4 : 16;
        logic [CW-1:0] ifc;
        logic [CW-1:0] memc;

        memory_arbiter #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (11),
            .ARB_MODE   ((g == 1) ? 1 : 0),
            .CNT_WIDTH  (CW)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .if_req_valid  (if_v),
            .if_req_ready  (if_rdy[g]),
            .if_addr       (if_a),
            .if_rsp_valid  (if_rv[g]),
            .if_rsp_data   (if_rd[g]),
            .mem_req_valid (m_v),
            .mem_req_ready (mem_rdy[g]),
            .mem_req_write (m_w),
            .mem_addr      (m_a),
            .mem_wdata     (m_d),
            .mem_wstrb     (m_s),
            .mem_rsp_valid (mem_rv[g]),
            .mem_rsp_data  (mem_rd[g]),
            .if_stall_cnt  (ifc),
            .mem_stall_cnt (memc)
        );

        assign if_sc[g]  = 16'(ifc);
        assign mem_sc[g] = 16'(memc);
    end

    // ---------------------------------------------------------------- model --
    bit [31:0] m_ram [N][2048];
    bit [3:0]  m_kn  [N][2048];   // which bytes of each word have been written
    bit        md_last [N];       // 1 = MEM won the last accept
    bit        md_ifv  [N];
    bit        md_memv [N];
    bit [31:0] md_ifd  [N];
    bit [31:0] md_memd [N];
    bit        md_ifk  [N];       // expected data fully known
    bit        md_memk [N];
    int        md_ifc  [N];
    int        md_memc [N];

    // Returns {if_ready, mem_ready}.
    function automatic bit [1:0] grant(input int i, input logic rst,
                                       input logic ifv, input logic mv,
                                       input bit last);
        if (rst) return 2'b00;
        if (ifv && mv) begin
            if (i != 1) return 2'b01;
            return last ? 2'b10 : 2'b01;
        end
        return {ifv, mv};
    endfunction

    function automatic bit win_if(input int i);
        bit [1:0] g;
        g = grant(i, reset, if_v, m_v, md_last[i]);
        return g[1];
    endfunction

    function automatic bit win_mem(input int i);
        bit [1:0] g;
        g = grant(i, reset, if_v, m_v, md_last[i]);
        return g[0];
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                md_last[i] <= 1'b0;
                md_ifv[i]  <= 1'b0;
                md_memv[i] <= 1'b0;
                md_ifd[i]  <= '0;
                md_memd[i] <= '0;
                md_ifk[i]  <= 1'b1;
                md_memk[i] <= 1'b1;
                md_ifc[i]  <= 0;
                md_memc[i] <= 0;
            end else begin
                md_ifv[i]  <= win_if(i);
                md_memv[i] <= win_mem(i);
                if (win_if(i)) begin
                    md_last[i] <= 1'b0;
                    md_ifd[i]  <= m_ram[i][if_a];
                    md_ifk[i]  <= (m_kn[i][if_a] == 4'hF);
                end
                if (win_mem(i)) begin
                    md_last[i] <= 1'b1;
                    if (m_w) begin
                        m_ram[i][m_a] <= merge(m_ram[i][m_a], m_d, m_s);
                        m_kn[i][m_a]  <= m_kn[i][m_a] | m_s;
                    end else begin
                        md_memd[i] <= m_ram[i][m_a];
                        md_memk[i] <= (m_kn[i][m_a] == 4'hF);
                    end
                end
                if (if_v && !win_if(i) && md_ifc[i] < cmax(i))
                    md_ifc[i] <= md_ifc[i] + 1;
                if (m_v && !win_mem(i) && md_memc[i] < cmax(i))
                    md_memc[i] <= md_memc[i] + 1;
            end
        end
    end

    // -------------------------------------------------------------- compare --
    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)",
                     name, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check("if_req_ready",  i, 32'(if_rdy[i]),  32'(win_if(i)));
            check("mem_req_ready", i, 32'(mem_rdy[i]), 32'(win_mem(i)));
            check("if_rsp_valid",  i, 32'(if_rv[i]),   32'(md_ifv[i]));
            check("mem_rsp_valid", i, 32'(mem_rv[i]),  32'(md_memv[i]));
            if (md_ifk[i])  check("if_rsp_data",  i, if_rd[i],  md_ifd[i]);
            if (md_memk[i]) check("mem_rsp_data", i, mem_rd[i], md_memd[i]);
            check("if_stall_cnt",  i, 32'(if_sc[i]),  32'(md_ifc[i]));
            check("mem_stall_cnt", i, 32'(mem_sc[i]), 32'(md_memc[i]));
        end

        // Hand-computed expectations pinning the model.
        if (probe == P_IDLE || probe == P_RST) begin
            for (int i = 0; i < N; i++) begin
                check("lit_idle_if_rdy",  i, 32'(if_rdy[i]),  32'd0);
                check("lit_idle_mem_rdy", i, 32'(mem_rdy[i]), 32'd0);
                check("lit_idle_if_rv",   i, 32'(if_rv[i]),   32'd0);
                check("lit_idle_mem_rv",  i, 32'(mem_rv[i]),  32'd0);
                check("lit_idle_if_rd",   i, if_rd[i],        32'd0);
                check("lit_idle_if_sc",   i, 32'(if_sc[i]),   32'd0);
                check("lit_idle_mem_sc",  i, 32'(mem_sc[i]),  32'd0);
            end
        end
        if (probe == P_WR_RSP) begin
            for (int i = 0; i < N; i++) check("lit_wr_rsp", i, 32'(mem_rv[i]), 32'd1);
        end
        if (probe == P_RD_BEEF) begin
            for (int i = 0; i < N; i++) begin
                check("lit_rd_rv",   i, 32'(mem_rv[i]), 32'd1);
                check("lit_rd_data", i, mem_rd[i],      32'hDEADBEEF);
            end
        end
        if (probe == P_IF_AA) begin
            for (int i = 0; i < N; i++) begin
                check("lit_if_rv",   i, 32'(if_rv[i]), 32'd1);
                check("lit_if_data", i, if_rd[i],      32'hDEADBEAA);
            end
        end
        if (probe == P_IF_END) begin
            for (int i = 0; i < N; i++) begin
                check("lit_if_pulse_end", i, 32'(if_rv[i]), 32'd0);
                check("lit_if_data_hold", i, if_rd[i],      32'hDEADBEAA);
            end
        end
        if (probe >= P_CONF && probe < P_CONF + 4) begin
            check("lit_fixed_mem_rdy", 0, 32'(mem_rdy[0]), 32'd1);
            check("lit_fixed_if_rdy",  0, 32'(if_rdy[0]),  32'd0);
            check("lit_rr_mem_rdy",    1, 32'(mem_rdy[1]), (probe % 2 == 0) ? 32'd1 : 32'd0);
            check("lit_rr_if_rdy",     1, 32'(if_rdy[1]),  (probe % 2 == 0) ? 32'd0 : 32'd1);
        end
        if (probe == P_AFTER) begin
            check("lit_if_after_mem", 0, 32'(if_rdy[0]), 32'd1);
            check("lit_if_sc_fixed",  0, 32'(if_sc[0]),  32'd4);
            check("lit_mem_sc_fixed", 0, 32'(mem_sc[0]), 32'd0);
            check("lit_if_sc_rr",     1, 32'(if_sc[1]),  32'd2);
            check("lit_mem_sc_rr",    1, 32'(mem_sc[1]), 32'd2);
        end
        if (probe == P_SAT) begin
            check("lit_if_sc_sat",    2, 32'(if_sc[2]),  32'd15);
            check("lit_if_sc_wide",   0, 32'(if_sc[0]),  32'd20);
            check("lit_if_sc_rr20",   1, 32'(if_sc[1]),  32'd10);
            check("lit_mem_sc_rr20",  1, 32'(mem_sc[1]), 32'd10);
        end
        if (probe == P_RD7) begin
            for (int i = 0; i < N; i++) begin
                check("lit_rst_write_dropped_rv",   i, 32'(mem_rv[i]), 32'd1);
                check("lit_rst_write_dropped_data", i, mem_rd[i],      32'h11111111);
            end
        end
    end

    // ------------------------------------------------------------- stimulus --
    // Inputs change 1 time unit after the rising edge; the probe applies to the
    // following falling edge.
    task automatic step(input int pr, input logic rst,
                        input logic iv, input logic [10:0] ia,
                        input logic mv, input logic mw, input logic [10:0] ma,
                        input logic [31:0] md, input logic [3:0] ms);
        @(posedge clk);
        #1;
        probe = pr;
        reset = rst;
        if_v  = iv;
        if_a  = ia;
        m_v   = mv;
        m_w   = mw;
        m_a   = ma;
        m_d   = md;
        m_s   = ms;
    endtask

    task automatic idle(input int pr, input logic rst);
        step(pr, rst, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    endtask

    initial begin
        reset = 1'b1;
        probe = P_NONE;
        if_v  = 1'b0;
        if_a  = '0;
        m_v   = 1'b0;
        m_w   = 1'b0;
        m_a   = '0;
        m_d   = '0;
        m_s   = '0;

        // Reset, then idle.
        idle(P_NONE, 1'b1);
        idle(P_NONE, 1'b1);
        for (int k = 0; k < 5; k++) idle(P_IDLE, 1'b0);

        // Full write, read back, partial write, IF read.
        step(P_NONE,    1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'd5, 32'hDEADBEEF, 4'hF);
        step(P_WR_RSP,  1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd5, 32'h0,        4'h0);
        step(P_RD_BEEF, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'd5, 32'h000000AA, 4'b0001);
        step(P_WR_RSP,  1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'h0,        4'h0);
        idle(P_IF_AA,  1'b0);
        idle(P_IF_END, 1'b0);

        // Conflicts from reset: both request addr 5 for 4 cycles, then MEM drops.
        idle(P_NONE, 1'b1);
        idle(P_NONE, 1'b1);
        idle(P_NONE, 1'b0);
        for (int k = 0; k < 4; k++)
            step(P_CONF + k, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        step(P_AFTER, 1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'h0, 4'h0);
        idle(P_NONE, 1'b0);

        // 20 conflict cycles: narrow counter saturates.
        idle(P_NONE, 1'b1);
        idle(P_NONE, 1'b0);
        for (int k = 0; k < 20; k++)
            step(P_NONE, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd5, 32'h0, 4'h0);
        idle(P_SAT, 1'b0);

        // Reset over a pending IF read and a MEM write; the write must not land.
        step(P_NONE, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'd7, 32'h11111111, 4'hF);
        idle(P_NONE, 1'b0);
        step(P_NONE, 1'b1, 1'b1, 11'd5, 1'b1, 1'b1, 11'd7, 32'h22222222, 4'hF);
        step(P_NONE, 1'b1, 1'b1, 11'd5, 1'b1, 1'b1, 11'd7, 32'h22222222, 4'hF);
        idle(P_RST, 1'b0);
        step(P_NONE, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd7, 32'h0, 4'h0);
        idle(P_RD7,  1'b0);
        idle(P_NONE, 1'b0);
        idle(P_NONE, 1'b0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Parametrised single-port memory shared by two requesters: instruction fetch (IF, read-only) and data access (MEM, read/write with byte strobes).
- Arbitrates one access per cycle and uses valid/ready request and response handshakes instead of wait flags.
- Fixed-priority or round-robin arbitration.
- Sits between the IF and MEM pipeline stages and the on-chip word-addressed RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 11, word address width; depth = 2**ADDR_WIDTH words.
- ARB_MODE, 0, 0 = MEM always wins conflicts; 1 = round-robin, alternating on conflict.
- CNT_WIDTH, 16, width of the saturating stall counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle (combinational).
- if_addr  in  ADDR_WIDTH  IF word address.
- if_rsp_valid  out  1  IF read data valid, one-cycle pulse.
- if_rsp_data  out  DATA_WIDTH  IF read data.
- mem_req_valid  in  1  MEM request.
- mem_req_ready  out  1  MEM request accepted this cycle (combinational).
- mem_req_write  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_WIDTH  MEM word address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wstrb  in  DATA_WIDTH/8  byte enables; bit i enables byte i (bits 8i+7:8i).
- mem_rsp_valid  out  1  MEM completion pulse for reads and writes.
- mem_rsp_data  out  DATA_WIDTH  MEM read data.
- if_stall_cnt  out  CNT_WIDTH  cycles with if_req_valid && !if_req_ready.
- mem_stall_cnt  out  CNT_WIDTH  cycles with mem_req_valid && !mem_req_ready.

Behaviour:
- Reset values:
  - All outputs 0.
  - last_grant = IF, so MEM wins the first conflict in round-robin mode.
  - RAM contents are not reset.
- Ready (combinational from the valid inputs and last_grant):
  - Only one requester valid: that requester is ready.
  - Both valid, ARB_MODE=0: MEM is ready.
  - Both valid, ARB_MODE=1: the requester not equal to last_grant is ready.
  - Neither valid: both readys are 0.
  - Ready never depends on rsp signals.
  - Exactly one ready at most per cycle.
- Accept: occurs at the rising edge where valid && ready. last_grant updates to the accepted requester on every accept.
- Requester rules: must hold valid, address, write, wdata and wstrb stable until accepted. Valid may be withdrawn only after accept.
- Read latency: exactly 1 cycle. rsp_valid is high for the single cycle after accept, and rsp_data carries mem[addr] sampled at the accept edge.
- rsp_data holds its last value when rsp_valid is 0 and is not updated by writes.
- Write:
  - At the accept edge, only strobed bytes are updated. mem_wstrb = 0 is a no-op write that still completes.
  - mem_rsp_valid pulses 1 cycle after accept.
- Read-after-write to the same address in the next cycle returns the new data; no bypass is needed since one access happens per cycle.
- Throughput: one accept per cycle; back-to-back accepts from the same or alternating requesters are allowed with no bubble.
- Stall counters:
  - Increment each cycle the condition holds.
  - Saturate at 2**CNT_WIDTH-1; no wrap.
  - Cleared only by reset.
- Reset mid-operation: an rsp_valid pending for the next cycle is dropped. A write whose accept edge coincides with reset asserted is not performed.
- No response backpressure: requesters must always accept rsp.

Test Plan:
- Reset then idle: all outputs 0 and both readys 0 for 5 cycles.
- MEM write 0xDEADBEEF to addr 5 with wstrb=4'hF, then read addr 5 -> mem_rsp_valid pulses twice and read data = 0xDEADBEEF one cycle after the read accept.
- Write 0x000000AA to addr 5 with wstrb=4'b0001 over 0xDEADBEEF, then IF read addr 5 -> if_rsp_data = 0xDEADBEAA with if_rsp_valid a 1-cycle pulse.
- ARB_MODE=0, both valid continuously for 4 cycles:
  - mem_req_ready=1 every cycle and if_req_ready=0.
  - if_stall_cnt = 4 after those 4 cycles.
  - After MEM drops valid, IF is accepted the next cycle.
- ARB_MODE=1, both valid for 4 cycles from reset -> accept order MEM, IF, MEM, IF; each stall counter = 2.
- CNT_WIDTH=4, IF stalled for 20 cycles -> if_stall_cnt saturates at 15. Assert reset mid-read -> no if_rsp_valid pulse and counters return to 0.
